// File: rtl/zoom_pkg.sv
// Shared constants, FSM encoding and sizing helpers for the zoom engine.
package zoom_pkg;

  localparam logic [1:0] MODE_NN   = 2'b00;
  localparam logic [1:0] MODE_DEC  = 2'b01;
  localparam logic [1:0] MODE_AVG  = 2'b10;
  localparam logic [1:0] MODE_COPY = 2'b11;

  localparam int unsigned OUT_W_BITS = 10;
  localparam int unsigned OUT_H_BITS = 9;

  typedef logic [2:0] state_t;

  localparam state_t StIdle  = 3'd0;
  localparam state_t StCheck = 3'd1;
  localparam state_t StRun   = 3'd2;
  localparam state_t StFlush = 3'd3;
  localparam state_t StFin   = 3'd4;

  // Sum of a full 2^MAX_SHIFT x 2^MAX_SHIFT block of PIX_W-bit pixels.
  function automatic int unsigned acc_width(input int unsigned pix_w,
                                            input int unsigned max_shift);
    return pix_w + 2 * max_shift;
  endfunction

endpackage

// File: rtl/zoom_addr_gen.sv
// Raster and block address generator: destination x/y counters, averaging
// sub-block counters and multiplier-free source row-base accumulation.
module zoom_addr_gen
  import zoom_pkg::*;
#(
  parameter int unsigned SRC_W     = 160,
  parameter int unsigned SRC_AW    = 15,
  parameter int unsigned DST_AW    = 17,
  parameter int unsigned MAX_SHIFT = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic                  step,
  input  logic [1:0]            mode,
  input  logic [1:0]            k,
  input  logic [OUT_W_BITS-1:0] out_w,
  input  logic [OUT_H_BITS-1:0] out_h,
  output logic [SRC_AW-1:0]     src_addr,
  output logic [DST_AW-1:0]     dst_addr,
  output logic                  rd_slot,
  output logic                  last_in_block,
  output logic                  last_step
);

  localparam int unsigned SB = (MAX_SHIFT > 0) ? MAX_SHIFT : 1;
  localparam logic [SRC_AW-1:0] SrcWStep = SRC_AW'(SRC_W);

  logic [OUT_W_BITS-1:0] x_q;
  logic [OUT_H_BITS-1:0] y_q;
  logic [DST_AW-1:0]     dst_q;
  logic [SB-1:0]         bx_q, by_q;
  logic                  idle_q;
  logic [SRC_AW-1:0]     row_base_q, sub_base_q;

  logic              avg, nn;
  logic [SB-1:0]     mask;
  logic              blk_end, last_pix, x_end, y_wrap;
  logic [SRC_AW-1:0] col_ext, col, row_step;

  always_comb begin
    avg      = (mode == MODE_AVG);
    nn       = (mode == MODE_NN);
    mask     = SB'((32'd1 << k) - 32'd1);
    blk_end  = (bx_q == mask) && (by_q == mask);
    x_end    = (x_q == out_w - 1'b1);
    last_pix = x_end && (y_q == out_h - 1'b1);
    // Nearest-neighbour only moves to the next source row every 2^k output rows.
    y_wrap   = ((y_q[SB-1:0] & mask) == mask);
    col_ext  = SRC_AW'(x_q);
    col      = col_ext;
    row_step = SrcWStep;
    unique case (mode)
      MODE_NN:  col = col_ext >> k;
      MODE_DEC, MODE_AVG: begin
        col      = col_ext << k;
        row_step = SrcWStep << k;
      end
      MODE_COPY: col = col_ext;
    endcase
  end

  assign src_addr      = row_base_q + sub_base_q + col + SRC_AW'(bx_q);
  assign dst_addr      = dst_q;
  assign rd_slot       = !idle_q;
  assign last_in_block = !avg || blk_end;
  assign last_step     = last_pix && (!avg || idle_q);

  always_ff @(posedge clk) begin
    if (reset || init) begin
      x_q        <= '0;
      y_q        <= '0;
      dst_q      <= '0;
      bx_q       <= '0;
      by_q       <= '0;
      idle_q     <= 1'b0;
      row_base_q <= '0;
      sub_base_q <= '0;
    end else if (step) begin
      if (avg && !idle_q) begin
        if (bx_q == mask) begin
          bx_q <= '0;
          if (by_q == mask) begin
            by_q       <= '0;
            sub_base_q <= '0;
            idle_q     <= 1'b1;
          end else begin
            by_q       <= by_q + 1'b1;
            sub_base_q <= sub_base_q + SrcWStep;
          end
        end else begin
          bx_q <= bx_q + 1'b1;
        end
      end else begin
        idle_q <= 1'b0;
        dst_q  <= dst_q + 1'b1;
        if (x_end) begin
          x_q <= '0;
          y_q <= y_q + 1'b1;
          if (!nn || y_wrap) row_base_q <= row_base_q + row_step;
        end else begin
          x_q <= x_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/zoom_engine.sv
// Image rescaling engine: ROM source frame to RAM raster, with NN zoom-in,
// decimation, block averaging and copy, plus configuration validation.
module zoom_engine
  import zoom_pkg::*;
#(
  parameter int unsigned SRC_W     = 160,
  parameter int unsigned SRC_H     = 120,
  parameter int unsigned PIX_W     = 8,
  parameter int unsigned SRC_AW    = 15,
  parameter int unsigned DST_AW    = 17,
  parameter int unsigned MAX_SHIFT = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [1:0]            shift,
  output logic [SRC_AW-1:0]     src_addr,
  input  logic [PIX_W-1:0]      src_data,
  output logic [DST_AW-1:0]     dst_addr,
  output logic [PIX_W-1:0]      dst_data,
  output logic                  dst_wren,
  output logic [OUT_W_BITS-1:0] out_width,
  output logic [OUT_H_BITS-1:0] out_height,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned ACC_W    = acc_width(PIX_W, MAX_SHIFT);
  localparam logic [63:0] SrcPix   = 64'(SRC_W) * 64'(SRC_H);
  localparam logic [63:0] DstDepth = 64'd1 << DST_AW;
  localparam logic [31:0] OutWMax  = 32'((1 << OUT_W_BITS) - 1);
  localparam logic [31:0] OutHMax  = 32'((1 << OUT_H_BITS) - 1);

  state_t                state_q;
  logic [1:0]            mode_q, k_q;
  logic [OUT_W_BITS-1:0] out_w_q;
  logic [OUT_H_BITS-1:0] out_h_q;
  logic                  rej_q;

  logic                  v1_q, lib1_q, wren2_q;
  logic [DST_AW-1:0]     da1_q, da2_q;
  logic [ACC_W-1:0]      acc_q;
  logic [PIX_W-1:0]      avg_q;

  logic [31:0]       w_new, h_new;
  logic [63:0]       pix_new;
  logic              cfg_bad, avg_mode, issue;
  logic              rd_slot, last_in_block, last_step;
  logic [DST_AW-1:0] gen_dst;
  logic [ACC_W-1:0]  sum;

  // Output size is derived from the source size by shifts, so the capacity
  // check needs no runtime multiplier.
  always_comb begin
    w_new   = 32'(SRC_W);
    h_new   = 32'(SRC_H);
    pix_new = SrcPix;
    unique case (mode_q)
      MODE_NN: begin
        w_new   = 32'(SRC_W) << k_q;
        h_new   = 32'(SRC_H) << k_q;
        pix_new = SrcPix << {k_q, 1'b0};
      end
      MODE_DEC, MODE_AVG: begin
        w_new   = 32'(SRC_W) >> k_q;
        h_new   = 32'(SRC_H) >> k_q;
        pix_new = SrcPix >> {k_q, 1'b0};
      end
      MODE_COPY: ;
    endcase
    cfg_bad = ((mode_q != MODE_COPY) && (k_q == 2'd0)) || (32'(k_q) > MAX_SHIFT) ||
              (pix_new > DstDepth) || (w_new > OutWMax) || (h_new > OutHMax);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      mode_q  <= MODE_NN;
      k_q     <= 2'd0;
      out_w_q <= OUT_W_BITS'(SRC_W);
      out_h_q <= OUT_H_BITS'(SRC_H);
      rej_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StCheck;
            mode_q  <= mode;
            k_q     <= (mode == MODE_COPY) ? 2'd0 : shift;
            rej_q   <= 1'b0;
          end
        end
        StCheck: begin
          if (cfg_bad) begin
            rej_q   <= 1'b1;
            state_q <= StFin;
          end else begin
            out_w_q <= w_new[OUT_W_BITS-1:0];
            out_h_q <= h_new[OUT_H_BITS-1:0];
            state_q <= StRun;
          end
        end
        StRun:   if (last_step) state_q <= StFlush;
        StFlush: state_q <= StFin;
        StFin:   state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign avg_mode = (mode_q == MODE_AVG);
  assign issue    = (state_q == StRun) && rd_slot;

  zoom_addr_gen #(
    .SRC_W     (SRC_W),
    .SRC_AW    (SRC_AW),
    .DST_AW    (DST_AW),
    .MAX_SHIFT (MAX_SHIFT)
  ) u_addr_gen (
    .clk           (clk),
    .reset         (reset),
    .init          (state_q == StCheck),
    .step          (state_q == StRun),
    .mode          (mode_q),
    .k             (k_q),
    .out_w         (out_w_q),
    .out_h         (out_h_q),
    .src_addr      (src_addr),
    .dst_addr      (gen_dst),
    .rd_slot       (rd_slot),
    .last_in_block (last_in_block),
    .last_step     (last_step)
  );

  assign sum = acc_q + ACC_W'(src_data);

  // Stage 1 tracks the outstanding ROM read; stage 2 holds the block average.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q    <= 1'b0;
      lib1_q  <= 1'b0;
      da1_q   <= '0;
      wren2_q <= 1'b0;
      da2_q   <= '0;
      acc_q   <= '0;
      avg_q   <= '0;
    end else begin
      v1_q    <= issue;
      lib1_q  <= last_in_block;
      da1_q   <= gen_dst;
      wren2_q <= v1_q && lib1_q && avg_mode;
      da2_q   <= da1_q;
      if (state_q == StCheck) begin
        acc_q <= '0;
      end else if (v1_q && avg_mode) begin
        if (lib1_q) begin
          acc_q <= '0;
          avg_q <= PIX_W'(sum >> {k_q, 1'b0});
        end else begin
          acc_q <= sum;
        end
      end
    end
  end

  assign dst_wren   = avg_mode ? wren2_q : v1_q;
  assign dst_addr   = avg_mode ? da2_q : da1_q;
  assign dst_data   = !dst_wren ? '0 : (avg_mode ? avg_q : src_data);
  assign out_width  = out_w_q;
  assign out_height = out_h_q;
  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StFin);
  assign err        = (state_q == StFin) && rej_q;

endmodule

// File: tb/tb_zoom_engine.sv
// Directed bench for zoom_engine on a reduced 32x24 frame with a 4096-entry RAM.
module tb_zoom_engine;

  localparam int unsigned SW  = 32;
  localparam int unsigned SH  = 24;
  localparam int unsigned PW  = 8;
  localparam int unsigned SAW = 10;
  localparam int unsigned DAW = 12;
  localparam int unsigned MS  = 2;
  localparam int          NPIX  = SW * SH;
  localparam int          DEPTH = 1 << DAW;

  logic           clk = 1'b0;
  logic           reset, start;
  logic [1:0]     mode, shift;
  logic [SAW-1:0] src_addr;
  logic [PW-1:0]  src_data;
  logic [DAW-1:0] dst_addr;
  logic [PW-1:0]  dst_data;
  logic           dst_wren;
  logic [9:0]     out_width;
  logic [8:0]     out_height;
  logic           busy, done, err;

  logic [7:0] rom [0:NPIX-1];
  logic [7:0] ram [0:DEPTH-1];

  int checks = 0;
  int errors = 0;
  int wr_cnt, done_cnt, err_cnt, last_waddr;

  always #5 clk = ~clk;

  zoom_engine #(
    .SRC_W     (SW),
    .SRC_H     (SH),
    .PIX_W     (PW),
    .SRC_AW    (SAW),
    .DST_AW    (DAW),
    .MAX_SHIFT (MS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .mode       (mode),
    .shift      (shift),
    .src_addr   (src_addr),
    .src_data   (src_data),
    .dst_addr   (dst_addr),
    .dst_data   (dst_data),
    .dst_wren   (dst_wren),
    .out_width  (out_width),
    .out_height (out_height),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always @(posedge clk) begin
    if (int'(src_addr) < NPIX) src_data <= rom[src_addr];
    else src_data <= 8'h00;
  end

  always @(negedge clk) begin
    if (dst_wren) begin
      ram[dst_addr] = dst_data;
      wr_cnt++;
      last_waddr = int'(dst_addr);
    end
    if (done) done_cnt++;
    if (err) err_cnt++;
  end

  task automatic rom_ramp();
    for (int i = 0; i < NPIX; i++) rom[i] = 8'(i);
  endtask

  task automatic ram_clear();
    for (int i = 0; i < DEPTH; i++) ram[i] = 8'hEE;
  endtask

  // Runs one job; n is the cycle count from START to DONE, first_wr the offset of the first write.
  task automatic run_job(input logic [1:0] m, input logic [1:0] s, input int poke_at,
                         output int n, output int first_wr);
    wr_cnt = 0; done_cnt = 0; err_cnt = 0; last_waddr = -1; first_wr = -1;
    @(posedge clk); #1;
    start = 1'b1; mode = m; shift = s;
    n = 0;
    do begin
      @(posedge clk); #1;
      start = 1'b0;
      n++;
      if (n == poke_at) begin start = 1'b1; mode = 2'b00; shift = 2'd1; end
      if (dst_wren && first_wr < 0) first_wr = n;
    end while (!done && n < 20000);
    checks++;
    if (!done) begin errors++; $display("FAIL job_timeout: done=%0b after %0d cycles", done, n); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; mode = 2'b00; shift = 2'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL reset_status: busy=%b done=%b err=%b want 000", busy, done, err); end
    checks++; if (dst_wren !== 1'b0 || dst_addr !== '0 || dst_data !== '0 || src_addr !== '0) begin
      errors++; $display("FAIL reset_ports: wren=%b daddr=%0d ddata=%0d saddr=%0d want 0",
                         dst_wren, dst_addr, dst_data, src_addr); end
    checks++; if (out_width !== 10'd32 || out_height !== 9'd24) begin
      errors++; $display("FAIL reset_size: %0dx%0d want 32x24", out_width, out_height); end
  endtask

  task automatic test_copy();
    int n, fw, bad;
    rom_ramp(); ram_clear();
    run_job(2'b11, 2'd1, -1, n, fw);
    checks++; if (n != NPIX + 3) begin errors++; $display("FAIL copy_len: %0d want %0d", n, NPIX + 3); end
    checks++; if (fw != 3) begin errors++; $display("FAIL copy_first_write: %0d want 3", fw); end
    checks++; if (wr_cnt != NPIX) begin errors++; $display("FAIL copy_writes: %0d want %0d", wr_cnt, NPIX); end
    checks++; if (out_width !== 10'd32 || out_height !== 9'd24) begin
      errors++; $display("FAIL copy_size: %0dx%0d want 32x24", out_width, out_height); end
    bad = 0;
    for (int i = 0; i < NPIX; i++) if (ram[i] !== rom[i]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL copy_data: %0d bad pixels want 0", bad); end
    checks++; if (err_cnt != 0 || done_cnt != 1) begin
      errors++; $display("FAIL copy_pulses: done=%0d err=%0d want 1 0", done_cnt, err_cnt); end
  endtask

  task automatic test_nn_x2();
    int n, fw, bad;
    rom_ramp(); ram_clear();
    run_job(2'b00, 2'd1, -1, n, fw);
    checks++; if (out_width !== 10'd64 || out_height !== 9'd48) begin
      errors++; $display("FAIL nn_size: %0dx%0d want 64x48", out_width, out_height); end
    checks++; if (wr_cnt != 3072 || n != 3075) begin
      errors++; $display("FAIL nn_count: writes=%0d len=%0d want 3072 3075", wr_cnt, n); end
    checks++; if (ram[0] !== rom[0] || ram[1] !== rom[0] || ram[64] !== rom[0] || ram[65] !== rom[0]) begin
      errors++; $display("FAIL nn_corner: %0d %0d %0d %0d want %0d", ram[0], ram[1], ram[64], ram[65], rom[0]); end
    checks++; if (ram[2] !== rom[1]) begin errors++; $display("FAIL nn_dst2: %0d want %0d", ram[2], rom[1]); end
    bad = 0;
    for (int y = 0; y < 48; y++)
      for (int x = 0; x < 64; x++) if (ram[y * 64 + x] !== rom[(y / 2) * SW + x / 2]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL nn_data: %0d bad pixels want 0", bad); end
  endtask

  task automatic test_reject();
    int n, fw;
    run_job(2'b00, 2'd2, -1, n, fw);
    checks++; if (n != 2 || err_cnt != 1 || done_cnt != 1) begin
      errors++; $display("FAIL rej_nn4: len=%0d err=%0d done=%0d want 2 1 1", n, err_cnt, done_cnt); end
    checks++; if (wr_cnt != 0) begin errors++; $display("FAIL rej_writes: %0d want 0", wr_cnt); end
    checks++; if (out_width !== 10'd64 || out_height !== 9'd48) begin
      errors++; $display("FAIL rej_size: %0dx%0d want 64x48", out_width, out_height); end
    run_job(2'b01, 2'd0, -1, n, fw);
    checks++; if (err_cnt != 1 || wr_cnt != 0) begin
      errors++; $display("FAIL rej_k0: err=%0d writes=%0d want 1 0", err_cnt, wr_cnt); end
    run_job(2'b10, 2'd3, -1, n, fw);
    checks++; if (err_cnt != 1 || n != 2) begin
      errors++; $display("FAIL rej_k3: err=%0d len=%0d want 1 2", err_cnt, n); end
  endtask

  task automatic test_dec_x4();
    int n, fw;
    rom_ramp(); ram_clear();
    run_job(2'b01, 2'd2, -1, n, fw);
    checks++; if (out_width !== 10'd8 || out_height !== 9'd6) begin
      errors++; $display("FAIL dec_size: %0dx%0d want 8x6", out_width, out_height); end
    checks++; if (ram[1] !== rom[4] || ram[8] !== rom[128]) begin
      errors++; $display("FAIL dec_data: %0d %0d want %0d %0d", ram[1], ram[8], rom[4], rom[128]); end
    checks++; if (last_waddr != 47 || wr_cnt != 48 || n != 51) begin
      errors++; $display("FAIL dec_end: last=%0d writes=%0d len=%0d want 47 48 51", last_waddr, wr_cnt, n); end
  endtask

  task automatic test_avg_x2();
    int n, fw, bad, s;
    rom_ramp(); ram_clear();
    rom[0] = 8'd10; rom[1] = 8'd11; rom[32] = 8'd12; rom[33] = 8'd13;
    run_job(2'b10, 2'd1, -1, n, fw);
    checks++; if (ram[0] !== 8'd11) begin errors++; $display("FAIL avg_dst0: %0d want 11", ram[0]); end
    checks++; if (wr_cnt != 192 || n != 963) begin
      errors++; $display("FAIL avg_count: writes=%0d len=%0d want 192 963", wr_cnt, n); end
    bad = 0;
    for (int y = 0; y < 12; y++)
      for (int x = 0; x < 16; x++) begin
        s = int'(rom[2 * y * SW + 2 * x]) + int'(rom[2 * y * SW + 2 * x + 1]) +
            int'(rom[(2 * y + 1) * SW + 2 * x]) + int'(rom[(2 * y + 1) * SW + 2 * x + 1]);
        if (ram[y * 16 + x] !== 8'(s / 4)) bad++;
      end
    checks++; if (bad != 0) begin errors++; $display("FAIL avg_data: %0d bad pixels want 0", bad); end
  endtask

  task automatic test_avg_sat();
    int n, fw, bad;
    for (int i = 0; i < NPIX; i++) rom[i] = 8'd255;
    ram_clear();
    run_job(2'b10, 2'd2, -1, n, fw);
    bad = 0;
    for (int i = 0; i < 48; i++) if (ram[i] !== 8'd255) bad++;
    checks++; if (bad != 0 || wr_cnt != 48) begin
      errors++; $display("FAIL avg_full: bad=%0d writes=%0d want 0 48", bad, wr_cnt); end
    checks++; if (n != 2 + 48 * 17 + 1) begin errors++; $display("FAIL avg4_len: %0d want %0d", n, 819); end
  endtask

  task automatic test_ignore_start();
    int n, fw;
    rom_ramp(); ram_clear();
    run_job(2'b11, 2'd0, 5, n, fw);
    checks++; if (n != NPIX + 3 || wr_cnt != NPIX) begin
      errors++; $display("FAIL ignore_len: len=%0d writes=%0d want %0d %0d", n, wr_cnt, NPIX + 3, NPIX); end
    checks++; if (out_width !== 10'd32 || done_cnt != 1) begin
      errors++; $display("FAIL ignore_state: width=%0d done=%0d want 32 1", out_width, done_cnt); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_idle: busy=%b want 0", busy); end
  endtask

  task automatic test_abort();
    done_cnt = 0; err_cnt = 0;
    rom_ramp();
    @(posedge clk); #1;
    start = 1'b1; mode = 2'b01; shift = 2'd2;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1 || dst_wren !== 1'b1) begin
      errors++; $display("FAIL abort_midjob: busy=%b wren=%b want 1 1", busy, dst_wren); end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (dst_wren !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL abort_stop: wren=%b busy=%b done=%b want 000", dst_wren, busy, done); end
    checks++; if (out_width !== 10'd32 || out_height !== 9'd24) begin
      errors++; $display("FAIL abort_size: %0dx%0d want 32x24", out_width, out_height); end
    start = 1'b1; mode = 2'b11;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_vs_start: busy=%b want 0", busy); end
    reset = 1'b0; start = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    checks++; if (done_cnt != 0 || err_cnt != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_quiet: done=%0d err=%0d busy=%b want 0 0 0", done_cnt, err_cnt, busy); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mode = 2'b00; shift = 2'd0;
    wr_cnt = 0; done_cnt = 0; err_cnt = 0; last_waddr = -1;
    rom_ramp();
    test_reset();
    test_copy();
    test_nn_x2();
    test_reject();
    test_dec_x4();
    test_avg_x2();
    test_avg_sat();
    test_ignore_start();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
